// File: rtl/sub_cmp_pkg.sv
// Shared definitions for the subtractor compare-result path.
//   CMP_LT/CMP_EQ/CMP_GT : one-hot {lt, eq, gt} encodings of a compare outcome
//   entry_t / ENTRY_W    : buffered result entry {diff, lt, eq, gt, ovf}, 8 bits
//   CW_DEF               : default event-counter width
package sub_cmp_pkg;

  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned ENTRY_W = 8;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  typedef struct packed {
    logic [3:0] diff;
    logic       lt;
    logic       eq;
    logic       gt;
    logic       ovf;
  } entry_t;

endpackage

// File: rtl/sub_cmp_flags.sv
// Combinational compare-flag derivation from a 4-bit ripple-borrow subtractor result.
//   d           : difference X-Y
//   bout        : borrow-out (X < Y unsigned)
//   x_msb/y_msb : sign bits of the operands
//   signed_mode : 1 = two's-complement compare, 0 = unsigned
//   lt/eq/gt    : compare outcome, exactly one high
//   ovf         : signed overflow of X-Y (always 0 in unsigned mode)
module sub_cmp_flags (
  input  logic [3:0] d,
  input  logic       bout,
  input  logic       x_msb,
  input  logic       y_msb,
  input  logic       signed_mode,
  output logic       lt,
  output logic       eq,
  output logic       gt,
  output logic       ovf
);

  logic sovf;

  // Overflow only when operand signs differ and the result sign disagrees with X.
  assign sovf = (x_msb ^ y_msb) & (d[3] ^ x_msb);

  assign eq  = (d == 4'd0);
  assign ovf = signed_mode & sovf;
  assign lt  = signed_mode ? (d[3] ^ sovf) : bout;
  assign gt  = ~lt & ~eq;

endmodule

// File: rtl/sub_cmp_result_buffer.sv
// Compare-result buffer downstream of the 4-bit subtractor.
// Derives lt/eq/gt/ovf per accepted operand pair, queues entries in a 2-deep FIFO with
// valid/ready on both sides, and keeps saturating per-outcome event counters.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : producer handshake (in_ready registered)
//   d, bout, x_msb, y_msb       : subtractor result and operand sign bits
//   signed_mode                 : compare mode, captured with each accepted entry
//   out_valid/out_ready         : consumer handshake
//   out_diff/out_lt/eq/gt/ovf   : head entry (hold last values while empty)
//   cnt_clr                     : synchronous clear of all counters, wins over a push
//   cnt_lt/cnt_eq/cnt_gt        : saturating outcome counts, advanced on push
module sub_cmp_result_buffer
  import sub_cmp_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    d,
  input  logic          bout,
  input  logic          x_msb,
  input  logic          y_msb,
  input  logic          signed_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_diff,
  output logic          out_lt,
  output logic          out_eq,
  output logic          out_gt,
  output logic          out_ovf,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt_lt,
  output logic [CW-1:0] cnt_eq,
  output logic [CW-1:0] cnt_gt
);

  localparam logic [1:0]    Full = 2'(DEPTH);
  localparam logic [CW-1:0] One  = {{(CW-1){1'b0}}, 1'b1};

  logic   f_lt, f_eq, f_gt, f_ovf;
  entry_t in_entry;

  sub_cmp_flags u_flags (
    .d           (d),
    .bout        (bout),
    .x_msb       (x_msb),
    .y_msb       (y_msb),
    .signed_mode (signed_mode),
    .lt          (f_lt),
    .eq          (f_eq),
    .gt          (f_gt),
    .ovf         (f_ovf)
  );

  assign in_entry = '{diff: d, lt: f_lt, eq: f_eq, gt: f_gt, ovf: f_ovf};

  entry_t        mem_q [2];
  entry_t        mem_d [2];
  entry_t        head_q, head_d;
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q, out_valid_q;
  logic          push, pop;
  logic [CW-1:0] cnt_lt_q, cnt_lt_d, cnt_eq_q, cnt_eq_d, cnt_gt_q, cnt_gt_d;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) mem_d[wr_ptr_q] = in_entry;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // The output register tracks the next head; it keeps its value once the FIFO drains.
    head_d = head_q;
    if (count_d != 2'd0) head_d = mem_d[rd_ptr_d];
  end

  always_comb begin
    cnt_lt_d = cnt_lt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_gt_d = cnt_gt_q;
    if (cnt_clr) begin
      cnt_lt_d = '0;
      cnt_eq_d = '0;
      cnt_gt_d = '0;
    end else if (push) begin
      unique case ({f_lt, f_eq, f_gt})
        CMP_LT:  if (cnt_lt_q != '1) cnt_lt_d = cnt_lt_q + One;
        CMP_EQ:  if (cnt_eq_q != '1) cnt_eq_d = cnt_eq_q + One;
        CMP_GT:  if (cnt_gt_q != '1) cnt_gt_d = cnt_gt_q + One;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      head_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_lt_q    <= '0;
      cnt_eq_q    <= '0;
      cnt_gt_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d != Full);
      out_valid_q <= (count_d != 2'd0);
      cnt_lt_q    <= cnt_lt_d;
      cnt_eq_q    <= cnt_eq_d;
      cnt_gt_q    <= cnt_gt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_diff  = head_q.diff;
  assign out_lt    = head_q.lt;
  assign out_eq    = head_q.eq;
  assign out_gt    = head_q.gt;
  assign out_ovf   = head_q.ovf;
  assign cnt_lt    = cnt_lt_q;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_gt    = cnt_gt_q;

endmodule

// File: tb/tb_sub_cmp_result_buffer.sv
module tb_sub_cmp_result_buffer;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [3:0]    d = 4'd0;
  logic          bout = 1'b0, x_msb = 1'b0, y_msb = 1'b0, signed_mode = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [3:0]    out_diff;
  logic          out_lt, out_eq, out_gt, out_ovf;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt_lt, cnt_eq, cnt_gt;

  int n_checks = 0;
  int n_fail   = 0;

  sub_cmp_result_buffer #(.DEPTH(2), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .d           (d),
    .bout        (bout),
    .x_msb       (x_msb),
    .y_msb       (y_msb),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .out_lt      (out_lt),
    .out_eq      (out_eq),
    .out_gt      (out_gt),
    .out_ovf     (out_ovf),
    .cnt_clr     (cnt_clr),
    .cnt_lt      (cnt_lt),
    .cnt_eq      (cnt_eq),
    .cnt_gt      (cnt_gt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic set_in(input logic v, input logic [3:0] dv, input logic b,
                        input logic xm, input logic ym, input logic sm);
    in_valid = v; d = dv; bout = b; x_msb = xm; y_msb = ym; signed_mode = sm;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out_diff, out_lt, out_eq, out_gt, out_ovf} !== 10'b01_0000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ready=%b diff=%h flags=%b%b%b%b, want 0 1 0 0000",
               out_valid, in_ready, out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, want 0/0/0", cnt_lt, cnt_eq, cnt_gt);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    out_ready = 1'b1;
    set_in(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);  // 5-3
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf} !== {1'b1, 4'd2, 4'b0010}) begin
      n_fail++;
      $display("FAIL unsigned_gt: got v=%b diff=%h flags=%b%b%b%b, want 1 2 0010",
               out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    set_in(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);  // 3-5
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf} !== {1'b1, 4'he, 4'b1000}) begin
      n_fail++;
      $display("FAIL unsigned_lt: got v=%b diff=%h flags=%b%b%b%b, want 1 e 1000",
               out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    set_in(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);  // 9-9
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf} !== {1'b1, 4'd0, 4'b0100}) begin
      n_fail++;
      $display("FAIL unsigned_eq: got v=%b diff=%h flags=%b%b%b%b, want 1 0 0100",
               out_valid, out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL unsigned_drained: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== {2'd1, 2'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL unsigned_counters: got %0d/%0d/%0d, want 1/1/1", cnt_lt, cnt_eq, cnt_gt);
    end
  endtask

  task automatic test_signed;
    set_in(1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1);  // -8 - 1 signed
    @(negedge clk);
    n_checks++;
    if ({out_diff, out_lt, out_eq, out_gt, out_ovf} !== {4'd7, 4'b1001}) begin
      n_fail++;
      $display("FAIL signed_ovf: got diff=%h flags=%b%b%b%b, want 7 1001",
               out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    set_in(1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);  // same bits, unsigned 8-1
    @(negedge clk);
    n_checks++;
    if ({out_diff, out_lt, out_eq, out_gt, out_ovf} !== {4'd7, 4'b0010}) begin
      n_fail++;
      $display("FAIL signed_as_unsigned: got diff=%h flags=%b%b%b%b, want 7 0010",
               out_diff, out_lt, out_eq, out_gt, out_ovf);
    end
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== {2'd2, 2'd1, 2'd2}) begin
      n_fail++;
      $display("FAIL signed_counters: got %0d/%0d/%0d, want 2/1/2", cnt_lt, cnt_eq, cnt_gt);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_in(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_diff} !== {2'b11, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_one: got ready=%b valid=%b diff=%h, want 1 1 1", in_ready, out_valid, out_diff);
    end
    set_in(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_diff} !== {2'b01, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_full: got ready=%b valid=%b diff=%h, want 0 1 1", in_ready, out_valid, out_diff);
    end
    set_in(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_diff, out_gt} !== {2'b01, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_stall_hold: got ready=%b valid=%b diff=%h gt=%b, want 0 1 1 1",
               in_ready, out_valid, out_diff, out_gt);
    end
    out_ready = 1'b1;  // pop while full; the held push must not be taken this cycle
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_diff} !== {2'b11, 4'd2}) begin
      n_fail++;
      $display("FAIL bp_drain_second: got ready=%b valid=%b diff=%h, want 1 1 2",
               in_ready, out_valid, out_diff);
    end
    @(negedge clk);  // push and pop together at count 1
    n_checks++;
    if ({in_ready, out_valid, out_diff} !== {2'b11, 4'd3}) begin
      n_fail++;
      $display("FAIL bp_push_pop: got ready=%b valid=%b diff=%h, want 1 1 3",
               in_ready, out_valid, out_diff);
    end
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_diff, out_gt} !== {1'b0, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_empty_hold: got valid=%b diff=%h gt=%b, want 0 3 1", out_valid, out_diff, out_gt);
    end
  endtask

  task automatic test_sat_clear;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_plain: got %0d/%0d/%0d, want 0/0/0", cnt_lt, cnt_eq, cnt_gt);
    end
    set_in(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== {2'd0, 2'd0, 2'd3}) begin
      n_fail++;
      $display("FAIL sat_gt: got %0d/%0d/%0d, want 0/0/3", cnt_lt, cnt_eq, cnt_gt);
    end
    cnt_clr = 1'b1;
    set_in(1'b1, 4'he, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cnt_clr = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_with_push: got %0d/%0d/%0d, want 0/0/0", cnt_lt, cnt_eq, cnt_gt);
    end
    n_checks++;
    if ({out_valid, out_diff, out_lt} !== {1'b1, 4'he, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_push_entered: got valid=%b diff=%h lt=%b, want 1 e 1", out_valid, out_diff, out_lt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    set_in(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({in_ready, out_valid, cnt_gt} !== {2'b01, 2'd2}) begin
      n_fail++;
      $display("FAIL mid_prefill: got ready=%b valid=%b cnt_gt=%0d, want 0 1 2", in_ready, out_valid, cnt_gt);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_diff, out_gt} !== {2'b01, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got valid=%b ready=%b diff=%h gt=%b, want 0 1 0 0",
               out_valid, in_ready, out_diff, out_gt);
    end
    n_checks++;
    if ({cnt_lt, cnt_eq, cnt_gt} !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_counters: got %0d/%0d/%0d, want 0/0/0", cnt_lt, cnt_eq, cnt_gt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_after: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_sat_clear();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_cmp_result_buffer.md
Name: sub_cmp_result_buffer

Overview:
- Downstream stage of the 4-bit ripple-borrow subtractor in the two's-complement compare path.
- Consumes difference D[3:0] and borrow-out per operand pair; derives LT/EQ/GT and overflow flags in unsigned or signed mode.
- Buffers results in a 2-entry FIFO with valid/ready handshakes on both sides; keeps saturating per-outcome event counters.
- Interface: one clock; reset is asynchronous and active-high.

Parameters:
- DEPTH, 2, result FIFO entries; fixed at 2, other values unsupported.
- CW, 8, width of each event counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  subtractor result present.
- in_ready  out  1  buffer can accept.
- d  in  4  difference X-Y from the subtractor.
- bout  in  1  borrow-out from the subtractor.
- x_msb  in  1  X[3], for signed overflow.
- y_msb  in  1  Y[3], for signed overflow.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with each accepted entry.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_diff  out  4  buffered difference.
- out_lt / out_eq / out_gt  out  1 each  compare flags of head entry, exactly one high when out_valid.
- out_ovf  out  1  signed overflow of head entry (0 in unsigned mode).
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_lt / cnt_eq / cnt_gt  out  CW each  saturating outcome counts.

Behaviour:
- Reset: FIFO empty, out_valid=0, in_ready=1, out_diff=0, all flags 0, counters 0. Reset mid-transfer discards all entries; no partial state survives.
- Flag derivation is combinational on the inputs and stored in the entry:
  - eq = (d==0).
  - Unsigned mode: lt = bout; ovf = 0.
  - Signed mode: ovf = (x_msb^y_msb) & (d[3]^x_msb); lt = d[3]^ovf.
  - In both modes, gt = ~lt & ~eq.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- FIFO:
  - Entry = {diff, lt, eq, gt, ovf}; occupancy count 0..2; in_ready = (count<2), registered.
  - Latency: an entry pushed in cycle N appears on out_* in cycle N+1. No combinational input-to-output pass-through.
  - Simultaneous push and pop with count=1: count stays 1, new entry becomes head on the next cycle.
  - Full (count=2): in_ready=0; pushes are not accepted even if a pop occurs in the same cycle.
  - Empty: out_valid=0 and out_* hold their last values; the consumer must ignore them.
  - Head and data are stable while out_valid & ~out_ready.
  - Read/write pointers are 1 bit and wrap.
- Counters:
  - On push, the matching counter increments by 1 and saturates at 2^CW-1 (no wrap).
  - cnt_clr has priority: with a simultaneous push, all counters become 0 and the push is not counted.
  - Counters advance on push, not pop.
- in_valid while in_ready=0 is not an error; the producer holds its data.

Decomposition:
- Shared package sub_cmp_pkg:
  - CMP_LT/CMP_EQ/CMP_GT one-hot encodings.
  - Entry struct/width constant (ENTRY_W=8).
  - CW default.
- One natural sub-module, sub_cmp_flags: the pure combinational flag derivation (d, bout, x_msb, y_msb, signed_mode -> lt, eq, gt, ovf), reused by the bench scoreboard.
- FIFO and counters stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with 2 entries queued -> out_valid=0, in_ready=1, counters 0 immediately (asynchronous).
- Unsigned: X=5,Y=3 (d=0010, bout=0) -> gt=1, diff=2. X=3,Y=5 (d=1110, bout=1) -> lt=1. X=Y=9 (d=0000) -> eq=1. Counters 1/1/1.
- Signed overflow: X=-8,Y=1 (d=0111, bout=0, x_msb=1, y_msb=0, signed_mode=1) -> ovf=1, lt=1. Same inputs unsigned -> gt=1, ovf=0.
- Backpressure: out_ready=0, push 3 back-to-back -> third held (in_ready=0 after 2 pushes). Release out_ready -> entries drain in order, one per cycle. Simultaneous push/pop at count=1 preserves order.
- Saturation/clear: CW=2, push 5 GT results -> cnt_gt=3. cnt_clr with a push in the same cycle -> all counters 0 next cycle.
